// File: rtl/brew_dispense_scheduler.sv
// brew_dispense_scheduler: arbitrates tea/coffee requests and sequences heater, grinder and valve
module brew_dispense_scheduler #(
  parameter int unsigned HEAT_TIMEOUT = 20,
  parameter int unsigned GRIND_CYC    = 6,
  parameter int unsigned POUR_TEA_CYC = 12,
  parameter int unsigned POUR_COF_CYC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_kind,
  output logic [1:0] req_ready,
  input  logic       water_ok,
  input  logic       coffee_ok,
  input  logic       temp_ok,
  output logic       heater_on,
  output logic       grinder_on,
  output logic       valve_on,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       resp_id
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_HEAT  = 3'd2;
  localparam logic [2:0] S_GRIND = 3'd3;
  localparam logic [2:0] S_POUR  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
  localparam logic [7:0] HEAT_LAST     = 8'(HEAT_TIMEOUT - 1);
  localparam logic [7:0] GRIND_LAST    = 8'(GRIND_CYC - 1);
  localparam logic [7:0] POUR_TEA_LAST = 8'(POUR_TEA_CYC - 1);
  localparam logic [7:0] POUR_COF_LAST = 8'(POUR_COF_CYC - 1);
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic       rr_q, rr_d;
  logic       id_q, id_d;
  logic       kind_q, kind_d;
  logic       pick, accept;
  logic [7:0] pour_last;
  // round-robin grant: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    pick = (req_valid == 2'b11) ? ~rr_q : req_valid[1];
    req_ready = (state_q == S_IDLE && |req_valid) ? (pick ? 2'b10 : 2'b01) : 2'b00;
    accept = |(req_valid & req_ready);
  end
  // sequence control; the counter restarts on every state change
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    kind_d = kind_q;
    code_d = code_q;
    pour_last = kind_q ? POUR_COF_LAST : POUR_TEA_LAST;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_CHECK;
        rr_d = pick;
        id_d = pick;
        kind_d = req_kind[pick];
      end
      S_CHECK: begin
        state_d = (!water_ok || (kind_q && !coffee_ok)) ? S_ERR : S_HEAT;
        code_d = !water_ok ? 2'b01 : 2'b10;
      end
      S_HEAT: if (temp_ok) state_d = kind_q ? S_GRIND : S_POUR;
        else if (cnt_q == HEAT_LAST) begin
          state_d = S_ERR;
          code_d = 2'b11;
        end
      S_GRIND: if (cnt_q == GRIND_LAST) state_d = S_POUR;
      S_POUR: if (!water_ok) begin
          state_d = S_ERR;
          code_d = 2'b01;
        end else if (cnt_q == pour_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? 8'd0 : cnt_q + 8'd1;
  end
  // Moore decode of actuators and status from the state register
  always_comb begin
    busy = state_q != S_IDLE;
    heater_on = state_q == S_HEAT || state_q == S_POUR;
    grinder_on = state_q == S_GRIND;
    valve_on = state_q == S_POUR;
    done = state_q == S_DONE;
    err = state_q == S_ERR;
    err_code = (state_q == S_ERR) ? code_q : 2'b00;
    resp_id = id_q;
  end
  // state registers; rr_q resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= 8'd0;
      code_q <= 2'b00;
      rr_q <= 1'b1;
      id_q <= 1'b0;
      kind_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      rr_q <= rr_d;
      id_q <= id_d;
      kind_q <= kind_d;
    end
  end
endmodule

// File: tb/tb_brew_dispense_scheduler.sv
// tb_brew_dispense_scheduler: table vectors, corner sequences and a randomized run against a procedural model
module tb_brew_dispense_scheduler;
  localparam int HT = 20;
  localparam int GC = 6;
  localparam int PT = 12;
  localparam int PC = 10;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_kind = 2'b00;
  logic [1:0] req_ready;
  logic       water_ok = 1'b1;
  logic       coffee_ok = 1'b1;
  logic       temp_ok = 1'b1;
  logic       heater_on, grinder_on, valve_on, busy, done, err, resp_id;
  logic [1:0] err_code;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic       port;
    logic       kind;
    logic       water;
    logic       coffee;
    logic       temp;
    int         lat;
    logic [1:0] code;
    int         heat;
    int         grind;
    int         valve;
  } vec_t;
  vec_t tbl[8];
  logic       m_idle = 1'b1;
  logic       m_last = 1'b1;
  logic       m_id = 1'b0;
  logic       m_busy, m_heat, m_grind, m_valve, m_done, m_err;
  logic [1:0] m_code;
  logic [1:0] taken = 2'b00;

  always #5 clk = ~clk;

  brew_dispense_scheduler #(
    .HEAT_TIMEOUT(HT), .GRIND_CYC(GC), .POUR_TEA_CYC(PT), .POUR_COF_CYC(PC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kind(req_kind), .req_ready(req_ready),
    .water_ok(water_ok), .coffee_ok(coffee_ok), .temp_ok(temp_ok),
    .heater_on(heater_on), .grinder_on(grinder_on), .valve_on(valve_on), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .resp_id(resp_id)
  );

  function automatic logic [10:0] obs();
    return {req_ready, busy, heater_on, grinder_on, valve_on, done, err, err_code, resp_id};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(obs()), 32'(0));
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("return_idle", 32'(busy), 32'(0));
  endtask

  task automatic m_set(input logic b, input logic h, input logic g, input logic v,
                       input logic d, input logic e, input logic [1:0] c);
    m_busy = b; m_heat = h; m_grind = g; m_valve = v; m_done = d; m_err = e; m_code = c;
  endtask

  // one drink at a time, walked through as timed phases; sensors are read at each edge
  task automatic model_run();
    logic k, ok;
    logic [1:0] code;
    int n;
    forever begin
      m_idle = 1'b1;
      m_set(0, 0, 0, 0, 0, 0, 2'b00);
      @(posedge clk);
      if (|req_valid) begin
        m_id = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        m_last = m_id;
        k = req_kind[m_id];
        taken[m_id] = 1'b1;
        m_idle = 1'b0;
        m_set(1, 0, 0, 0, 0, 0, 2'b00);
        @(posedge clk);
        code = 2'b00;
        if (!water_ok) code = 2'b01;
        else if (k && !coffee_ok) code = 2'b10;
        else begin
          ok = 1'b0;
          for (int i = 0; i < HT && !ok; i++) begin
            m_set(1, 1, 0, 0, 0, 0, 2'b00);
            @(posedge clk);
            ok = temp_ok;
          end
          if (!ok) code = 2'b11;
          else begin
            for (int i = 0; i < (k ? GC : 0); i++) begin
              m_set(1, 0, 1, 0, 0, 0, 2'b00);
              @(posedge clk);
            end
            n = k ? PC : PT;
            for (int i = 0; i < n && code == 2'b00; i++) begin
              m_set(1, 1, 0, 1, 0, 0, 2'b00);
              @(posedge clk);
              if (!water_ok) code = 2'b01;
            end
          end
        end
        m_set(1, 0, 0, 0, code == 2'b00, code != 2'b00, code);
        @(posedge clk);
      end
    end
  endtask

  initial begin
    int t, last, lat, h, g, vv, tmode;
    logic term, found;
    logic [1:0] exp_ready;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 15, 2'b00, 13, 0, 12};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19, 2'b00, 11, 6, 10};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2'b10, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15, 2'b00, 13, 0, 12};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2'b01, 0, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 2'b01, 0, 0, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 22, 2'b11, 20, 0, 0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 22, 2'b11, 20, 0, 0};
    do_reset();
    // both ports hold coffee requests: grants alternate, 20 cycles apart
    req_kind = 2'b11;
    req_valid = 2'b11;
    #1;
    t = 0;
    last = 0;
    for (int gi = 0; gi < 4; gi++) begin
      int w;
      w = 0;
      while (req_ready == 2'b00 && w < 40) begin
        @(negedge clk);
        #1;
        w++;
        t++;
      end
      chk($sformatf("rr_grant%0d", gi), 32'(req_ready), 32'(((gi % 2) == 1) ? 2'b10 : 2'b01));
      if (gi > 0) chk($sformatf("rr_gap%0d", gi), 32'(t - last), 32'(20));
      last = t;
      @(negedge clk);
      #1;
      t++;
      if (gi > 0 && gi < 3) chk("rr_busy_ready", 32'(req_ready), 32'(0));
    end
    req_valid = 2'b00;
    wait_idle();
    // single-transaction vectors
    for (int e = 0; e < 8; e++) begin
      vec_t v;
      v = tbl[e];
      water_ok = v.water;
      coffee_ok = v.coffee;
      temp_ok = v.temp;
      req_kind = {v.kind, v.kind};
      req_valid = v.port ? 2'b10 : 2'b01;
      #1;
      chk($sformatf("tbl%0d_ready", e), 32'(req_ready), 32'(v.port ? 2'b10 : 2'b01));
      lat = 0; h = 0; g = 0; vv = 0; term = 1'b0;
      while (!term && lat < 60) begin
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        lat++;
        h += int'(heater_on);
        g += int'(grinder_on);
        vv += int'(valve_on);
        term = done || err;
      end
      chk($sformatf("tbl%0d_lat", e), 32'(lat), 32'(v.lat));
      chk($sformatf("tbl%0d_outcome", e), 32'({done, err, err_code}),
          32'((v.code == 2'b00) ? 4'b1000 : {2'b01, v.code}));
      chk($sformatf("tbl%0d_resp_id", e), 32'(resp_id), 32'(v.port));
      chk($sformatf("tbl%0d_act_cycles", e), 32'(h * 65536 + g * 256 + vv),
          32'(v.heat * 65536 + v.grind * 256 + v.valve));
      chk($sformatf("tbl%0d_act_end", e), 32'({heater_on, grinder_on, valve_on}), 32'(0));
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_idle", e), 32'(busy), 32'(0));
    end
    // water lost in the 5th pour cycle
    water_ok = 1'b1; coffee_ok = 1'b1; temp_ok = 1'b1;
    req_kind = 2'b00;
    req_valid = 2'b01;
    #1;
    for (int l = 1; l <= 8; l++) begin
      @(negedge clk);
      req_valid = 2'b00;
      if (l == 7) water_ok = 1'b0;
      if (l == 8) water_ok = 1'b1;
      #1;
      if (l == 7) chk("wdrop_valve_on", 32'(valve_on), 32'(1));
      if (l == 8) chk("wdrop_err", 32'(obs()), 32'(11'b00_1_0_0_0_0_1_01_0));
    end
    @(negedge clk);
    #1;
    // temp_ok arrives on the last allowed heat cycle
    temp_ok = 1'b0;
    req_valid = 2'b10;
    #1;
    found = 1'b0;
    for (int l = 1; l <= 40 && !found; l++) begin
      @(negedge clk);
      req_valid = 2'b00;
      if (l == 21) temp_ok = 1'b1;
      #1;
      if (l == 21) chk("tlast_heat", 32'({heater_on, err}), 32'(2'b10));
      if (l == 22) chk("tlast_pour", 32'({valve_on, err}), 32'(2'b10));
      if (done || err) begin
        found = 1'b1;
        chk("tlast_done_lat", 32'(l), 32'(34));
        chk("tlast_done", 32'({done, err, resp_id}), 32'(3'b101));
      end
    end
    if (!found) chk("tlast_no_end", 32'(found), 32'(1));
    @(negedge clk);
    #1;
    // reset during grind, then a tie must go to port 0
    req_kind = 2'b01;
    req_valid = 2'b01;
    #1;
    for (int l = 1; l <= 5; l++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
    end
    chk("grind_before_rst", 32'(grinder_on), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_outputs", 32'(obs()), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    req_kind = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("rst_rr_port0", 32'(req_ready), 32'(2'b01));
    req_valid = 2'b00;
    // randomized run against the model
    do_reset();
    m_id = 1'b0;
    m_last = 1'b1;
    taken = 2'b00;
    tmode = 2;
    fork
      model_run();
    join_none
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 100 == 0) tmode = int'($urandom_range(0, 2));
      water_ok = ($urandom_range(0, 31) != 0);
      coffee_ok = ($urandom_range(0, 7) != 0);
      temp_ok = (tmode == 0) ? 1'b0 : (tmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (taken[i]) begin
          req_valid[i] = 1'b0;
          taken[i] = 1'b0;
        end
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_kind[i] = 1'($urandom_range(0, 1));
        end
      end
      #1;
      exp_ready = (m_idle && |req_valid) ?
                  (((req_valid == 2'b11) ? ~m_last : req_valid[1]) ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rand_c%0d", c), 32'(obs()),
          32'({exp_ready, m_busy, m_heat, m_grind, m_valve, m_done, m_err, m_code, m_id}));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
